// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter that shares one combinational adder among NUM_REQ requesters.
// Only one add is in flight; the registered sum is held until the consumer takes it.
module adder_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_src1,
  input  logic [NUM_REQ*WIDTH-1:0] req_src2,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         add_src1,
  output logic [WIDTH-1:0]         add_src2,
  input  logic [WIDTH-1:0]         add_out,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  input  logic                     rsp_ready,
  output logic                     busy
);

  // Handshakes: a request transfers on a cycle where req_valid[i] && req_ready[i];
  // a response transfers on a cycle where rsp_valid && rsp_ready. Valid never
  // waits on ready, and the response payload is stable while rsp_valid is high.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gnt;
  logic [WIDTH-1:0]   op1, op2;
  logic [ID_W-1:0]    grant;
  logic [ID_W-1:0]    cand;
  logic [ID_W-1:0]    ptr_next;
  logic               found;
  logic               accept;

  // Search rr_ptr, rr_ptr+1, ... (mod NUM_REQ) for the first active request.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((32'(rr_ptr) + 32'(i)) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  assign ptr_next  = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
  assign accept    = !rst && (state_q == IDLE) && found;
  assign req_ready = accept ? (NUM_REQ'(1) << grant) : '0;
  assign add_src1  = op1;
  assign add_src2  = op2;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = CALC;
      CALC:    state_d = HOLD;
      HOLD:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      gnt       <= '0;
      op1       <= '0;
      op2       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            op1    <= req_src1[grant*WIDTH +: WIDTH];
            op2    <= req_src2[grant*WIDTH +: WIDTH];
            gnt    <= grant;
            rr_ptr <= ptr_next;
          end
        end
        CALC: begin
          rsp_data  <= add_out;
          rsp_id    <= gnt;
          rsp_valid <= 1'b1;
        end
        HOLD: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter: hand-computed grants and sums, with an
// ideal adder modelled in the environment.
module tb_adder_rr_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_src1, req_src2;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   add_src1, add_src2, add_out;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_ready;
  logic           busy;

  int n_cmp = 0;
  int n_err = 0;

  adder_rr_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_src1(req_src1), .req_src2(req_src2),
    .req_ready(req_ready),
    .add_src1(add_src1), .add_src2(add_src2), .add_out(add_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;
  assign add_out = add_src1 + add_src2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b);
    req_src1[k*W +: W] = a;
    req_src2[k*W +: W] = b;
    req_valid[k] = 1'b1;
  endtask

  task automatic check_rsp(input string tag, input logic [1:0] id, input logic [31:0] data);
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_id"},    32'(rsp_id),    32'(id));
    check({tag, "_data"},  rsp_data,       data);
  endtask

  // Serve one already-granted request: drop it, wait for the response, consume it.
  task automatic serve(input string tag, input int k, input logic [31:0] sum);
    tick();
    req_valid[k] = 1'b0;
    settle();
    check({tag, "_calc_busy"},  32'(busy),      32'd1);
    check({tag, "_calc_ready"}, 32'(req_ready), 32'd0);
    tick();
    check_rsp(tag, 2'(k), sum);
    check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    tick();
    check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  // At most one ready bit at any time.
  always @(negedge clk) begin
    if (rst === 1'b0) check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
  end

  logic [31:0] sums [4];

  initial begin
    rst = 1'b1; req_valid = '0; req_src1 = '0; req_src2 = '0; rsp_ready = 1'b0;
    tick(); tick();
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id",    32'(rsp_id),    32'd0);
    check("rst_rsp_data",  rsp_data,       32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_add_src1",  add_src1,       32'd0);
    check("rst_add_src2",  add_src2,       32'd0);
    rst = 1'b0;

    // 1. single request, rsp_ready low at first
    set_req(0, 32'hFFFFFFFE, 32'hFFFFFFFD);
    settle();
    check("t1_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid[0] = 1'b0;
    settle();
    check("t1_ready_off", 32'(req_ready), 32'd0);
    check("t1_busy",      32'(busy),      32'd1);
    check("t1_rsp_early", 32'(rsp_valid), 32'd0);
    check("t1_add_src1",  add_src1,       32'hFFFFFFFE);
    check("t1_add_src2",  add_src2,       32'hFFFFFFFD);
    tick();
    check_rsp("t1", 2'd0, 32'hFFFFFFFB);
    tick();
    check_rsp("t1_stall", 2'd0, 32'hFFFFFFFB);
    rsp_ready = 1'b1;
    tick();
    check("t1_idle_valid", 32'(rsp_valid), 32'd0);
    check("t1_idle_busy",  32'(busy),      32'd0);

    // 2. all four from reset, rsp_ready held high: one add per 3 cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sums[0] = 32'd5; sums[1] = 32'hFFFFFFFF; sums[2] = 32'd1; sums[3] = 32'hFFFFFFFB;
    set_req(0, 32'd2,          32'd3);
    set_req(1, 32'd2,          32'hFFFFFFFD);
    set_req(2, 32'hFFFFFFFE,   32'd3);
    set_req(3, 32'hFFFFFFFE,   32'hFFFFFFFD);
    for (int k = 0; k < N; k++) begin
      settle();
      check("t2_grant", 32'(req_ready), 32'(1) << k);
      serve("t2", k, sums[k]);
    end

    // 3. response back-pressure with req1 pending
    rsp_ready = 1'b0;
    set_req(0, 32'd10, 32'd20);
    settle();
    check("t3_grant0", 32'(req_ready), 32'b0001);
    tick();
    req_valid[0] = 1'b0;
    set_req(1, 32'd7, 32'd8);
    settle();
    check("t3_calc_ready", 32'(req_ready), 32'd0);
    tick();
    for (int c = 0; c < 5; c++) begin
      check_rsp("t3_hold", 2'd0, 32'd30);
      check("t3_hold_ready", 32'(req_ready), 32'd0);
      tick();
    end
    check_rsp("t3_hold_last", 2'd0, 32'd30);
    rsp_ready = 1'b1;
    settle();
    check("t3_ack_ready", 32'(req_ready), 32'd0);
    tick();
    check("t3_released", 32'(rsp_valid), 32'd0);
    check("t3_grant1",   32'(req_ready), 32'b0010);
    serve("t3_req1", 1, 32'd15);

    // 4. pointer wrap: req3 alone, then req0 and req3 together
    set_req(3, 32'd100, 32'd1);
    settle();
    check("t4_grant3", 32'(req_ready), 32'b1000);
    serve("t4_req3", 3, 32'd101);
    set_req(0, 32'd40, 32'd2);
    set_req(3, 32'd50, 32'd5);
    settle();
    check("t4_wrap_grant0", 32'(req_ready), 32'b0001);
    serve("t4_req0", 0, 32'd42);
    settle();
    check("t4_then_grant3", 32'(req_ready), 32'b1000);
    serve("t4_req3b", 3, 32'd55);

    // 5. reset while in CALC
    set_req(1, 32'd9, 32'd9);
    settle();
    check("t5_grant1", 32'(req_ready), 32'b0010);
    tick();
    req_valid[1] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("t5_busy",  32'(busy),      32'd0);
    check("t5_valid", 32'(rsp_valid), 32'd0);
    tick();
    check("t5_valid_later", 32'(rsp_valid), 32'd0);
    set_req(1, 32'd11, 32'd22);
    set_req(3, 32'd33, 32'd44);
    settle();
    check("t5_ptr_zero_grant1", 32'(req_ready), 32'b0010);
    serve("t5_req1", 1, 32'd33);
    settle();
    check("t5_grant3", 32'(req_ready), 32'b1000);
    serve("t5_req3", 3, 32'd77);

    // 6. req2 withdraws while req1 is served
    set_req(1, 32'd1, 32'd1);
    set_req(2, 32'd5, 32'd5);
    settle();
    check("t6_grant1", 32'(req_ready), 32'b0010);
    tick();
    req_valid[1] = 1'b0;
    req_valid[2] = 1'b0;
    tick();
    check_rsp("t6_req1", 2'd1, 32'd2);
    tick();
    check("t6_ready_none", 32'(req_ready), 32'd0);
    tick();
    check("t6_idle_busy",  32'(busy),      32'd0);
    check("t6_no_rsp",     32'(rsp_valid), 32'd0);
    tick();
    check("t6_still_idle", 32'(busy),      32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
